// File: rtl/bit_stream_queue_pkg.sv
// Shared count width and modular index helper for the bit stream queue.
package bit_stream_queue_pkg;

  localparam int unsigned CNT_W = 32;

  // (a + b) mod m, valid when a < m and b <= m (single conditional subtract).
  function automatic logic [CNT_W-1:0] wrap_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b,
                                               input logic [CNT_W-1:0] m);
    logic [CNT_W-1:0] s;
    s = a + b;
    return (s >= m) ? (s - m) : s;
  endfunction

endpackage

// File: rtl/bit_stream_queue_read.sv
// Rotating read port: extracts OUT_WIDTH bits starting at head, zero past used.
module bit_stream_queue_read
  import bit_stream_queue_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 120,
  parameter int unsigned BUF_WIDTH = 2048
) (
  input  logic [BUF_WIDTH-1:0] storage,
  input  logic [CNT_W-1:0]     head,
  input  logic [CNT_W-1:0]     used,
  output logic [0:OUT_WIDTH-1] data
);

  localparam int unsigned AW = (BUF_WIDTH > 1) ? $clog2(BUF_WIDTH) : 1;

  // Gather each output bit from its wrapped storage position, masking unused bits.
  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      if (CNT_W'(i) < used) begin
        data[i] = storage[AW'(wrap_add(head, CNT_W'(i), CNT_W'(BUF_WIDTH)))];
      end
    end
  end

endmodule

// File: rtl/bit_stream_queue.sv
// Bit-granular circular FIFO: variable-width enqueue, variable-width dequeue,
// continuous peek of the oldest OUT_WIDTH bits.
module bit_stream_queue
  import bit_stream_queue_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 512,
  parameter int unsigned OUT_WIDTH = 120,
  parameter int unsigned BUF_WIDTH = 2048
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq,
  input  logic [CNT_W-1:0]     in_cnt,
  input  logic [0:IN_WIDTH-1]  in_data,
  input  logic                 deq,
  input  logic [CNT_W-1:0]     out_cnt,
  output logic [0:OUT_WIDTH-1] out_data,
  output logic [CNT_W-1:0]     used_cnt,
  output logic [CNT_W-1:0]     empty_cnt
);

  localparam int unsigned AW = (BUF_WIDTH > 1) ? $clog2(BUF_WIDTH) : 1;

  generate
    if (BUF_WIDTH < IN_WIDTH || BUF_WIDTH < OUT_WIDTH) begin : g_bad_params
      $error("bit_stream_queue: BUF_WIDTH must be >= IN_WIDTH and >= OUT_WIDTH");
    end
  endgenerate

  logic [CNT_W-1:0]     head;
  logic [CNT_W-1:0]     used;
  logic [CNT_W-1:0]     tail;
  logic                 enq_ok;
  logic                 deq_ok;
  logic [BUF_WIDTH-1:0] storage;
  logic [BUF_WIDTH-1:0] storage_d;

  // Status counts and request legality, judged only against pre-edge state.
  always_comb begin
    used_cnt  = used;
    empty_cnt = CNT_W'(BUF_WIDTH) - used;
    tail      = wrap_add(head, used, CNT_W'(BUF_WIDTH));
    enq_ok    = enq && (in_cnt <= CNT_W'(IN_WIDTH)) && (in_cnt <= empty_cnt);
    deq_ok    = deq && (out_cnt <= CNT_W'(OUT_WIDTH)) && (out_cnt <= used);
  end

  // Scatter the first in_cnt payload bits into storage starting at tail.
  always_comb begin
    storage_d = storage;
    if (enq_ok) begin
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
        if (CNT_W'(i) < in_cnt) begin
          storage_d[AW'(wrap_add(tail, CNT_W'(i), CNT_W'(BUF_WIDTH)))] = in_data[i];
        end
      end
    end
  end

  // Storage array; contents are don't-care until covered by used.
  always_ff @(posedge clk) begin
    storage <= storage_d;
  end

  // Head pointer and occupancy; reset discards all content.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      used <= '0;
    end else begin
      if (deq_ok) begin
        head <= wrap_add(head, out_cnt, CNT_W'(BUF_WIDTH));
      end
      used <= used + (enq_ok ? in_cnt : '0) - (deq_ok ? out_cnt : '0);
    end
  end

  bit_stream_queue_read #(
    .OUT_WIDTH(OUT_WIDTH),
    .BUF_WIDTH(BUF_WIDTH)
  ) u_read (
    .storage(storage),
    .head   (head),
    .used   (used),
    .data   (out_data)
  );

endmodule

// File: tb/tb_bit_stream_queue.sv
// Scoreboard bench for bit_stream_queue against a bit-queue reference model.
module tb_bit_stream_queue;

  localparam int unsigned IW = 512;
  localparam int unsigned OW = 120;
  localparam int unsigned BW = 2048;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enq = 1'b0;
  logic          deq = 1'b0;
  logic [31:0]   in_cnt = '0;
  logic [31:0]   out_cnt = '0;
  logic [0:IW-1] in_data = '0;
  logic [0:OW-1] out_data;
  logic [31:0]   used_cnt;
  logic [31:0]   empty_cnt;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  bit            model[$];
  logic [31:0]   exp_used_q[$];
  logic [0:OW-1] exp_out_q[$];
  string         exp_name_q[$];

  bit_stream_queue #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .BUF_WIDTH(BW)) dut (
    .clk(clk), .reset(reset), .enq(enq), .in_cnt(in_cnt), .in_data(in_data),
    .deq(deq), .out_cnt(out_cnt), .out_data(out_data),
    .used_cnt(used_cnt), .empty_cnt(empty_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_total++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, ex);
  endtask

  task automatic chkout(input string nm, input logic [0:OW-1] act, input logic [0:OW-1] ex);
    n_total++;
    if (act === ex) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, ex);
  endtask

  function automatic logic [0:OW-1] model_peek();
    logic [0:OW-1] r;
    r = '0;
    for (int i = 0; i < int'(OW); i++) if (i < model.size()) r[i] = model[i];
    return r;
  endfunction

  function automatic logic [0:IW-1] make_bytes(input int start);
    logic [0:IW-1] r;
    for (int k = 0; k < int'(IW / 8); k++) r[k*8 +: 8] = 8'(start + k);
    return r;
  endfunction

  function automatic logic [0:IW-1] rand_data();
    logic [0:IW-1] r;
    for (int k = 0; k < int'(IW / 32); k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drive one cycle of requests, update the model, queue the post-edge expectation.
  task automatic step(input string nm, input logic e, input int unsigned ic,
                      input logic [0:IW-1] d, input logic q, input int unsigned oc);
    int unsigned sz;
    bit eok, dok;
    @(negedge clk);
    enq = e; in_cnt = ic; in_data = d; deq = q; out_cnt = oc;
    sz  = model.size();
    eok = e && (ic <= IW) && (ic <= BW - sz);
    dok = q && (oc <= OW) && (oc <= sz);
    if (dok) for (int unsigned i = 0; i < oc; i++) model.delete(0);
    if (eok) for (int unsigned i = 0; i < ic; i++) model.push_back(d[i]);
    exp_used_q.push_back(32'(model.size()));
    exp_out_q.push_back(model_peek());
    exp_name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 0, '0, 1'b0, 0);
  endtask

  // Wait for the pending step to take effect before a directed check.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    enq = 1'b0; deq = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model.delete();
  endtask

  // Monitor: compare DUT state after every edge that has a queued expectation.
  initial begin
    logic [31:0]   eu;
    logic [0:OW-1] eo;
    string         en;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && exp_used_q.size() > 0) begin
        eu = exp_used_q.pop_front();
        eo = exp_out_q.pop_front();
        en = exp_name_q.pop_front();
        chk32({en, " used"}, used_cnt, eu);
        chk32({en, " empty"}, empty_cnt, 32'(BW) - eu);
        chkout({en, " out"}, out_data, eo);
      end
    end
  end

  initial begin
    logic [0:IW-1] d;
    logic [0:OW-1] eo;
    int            guard;

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and a full-width enqueue.
    idle("reset");
    settle();
    chk32("reset used", used_cnt, 32'd0);
    chk32("reset empty", empty_cnt, 32'd2048);
    chkout("reset out", out_data, '0);
    step("enq_aa", 1'b1, 512, {64{8'hAA}}, 1'b0, 0);
    settle();
    chk32("enq_aa used", used_cnt, 32'd512);
    chkout("enq_aa out", out_data, {15{8'hAA}});

    // Partial enqueue.
    do_reset();
    d = '0;
    d[0:31] = 32'h123456FF;
    step("partial", 1'b1, 24, d, 1'b0, 0);
    settle();
    chk32("partial used", used_cnt, 32'd24);
    chkout("partial out", out_data, {24'h123456, 96'h0});

    // Variable dequeue.
    do_reset();
    step("bytes_enq", 1'b1, 512, make_bytes(0), 1'b0, 0);
    step("deq24", 1'b0, 0, '0, 1'b1, 24);
    settle();
    chk32("deq24 used", used_cnt, 32'd488);
    d = make_bytes(3);
    chkout("deq24 out", out_data, d[0:OW-1]);

    // Simultaneous enqueue and dequeue, then read across the old/new boundary.
    do_reset();
    step("sim_fill", 1'b1, 512, make_bytes(0), 1'b0, 0);
    step("sim_both", 1'b1, 512, make_bytes(64), 1'b1, 120);
    settle();
    chk32("sim used", used_cnt, 32'd904);
    d = make_bytes(15);
    chkout("sim out", out_data, d[0:OW-1]);
    repeat (3) step("sim_drain", 1'b0, 0, '0, 1'b1, 120);
    settle();
    d = make_bytes(60);
    chkout("boundary out", out_data, d[0:OW-1]);

    // Wrap-around: move head to 2040 with an empty queue, then enqueue 64 bits.
    do_reset();
    step("wrap_pre", 1'b1, 120, rand_data(), 1'b0, 0);
    repeat (16) step("wrap_walk", 1'b1, 120, rand_data(), 1'b1, 120);
    step("wrap_drain", 1'b0, 0, '0, 1'b1, 120);
    d = '0;
    d[0:63] = 64'h0123456789ABCDEF;
    step("wrap_enq", 1'b1, 64, d, 1'b0, 0);
    settle();
    chk32("wrap used", used_cnt, 32'd64);
    chkout("wrap out", out_data, {64'h0123456789ABCDEF, 56'h0});
    step("wrap_more", 1'b1, 120, rand_data(), 1'b0, 0);
    step("wrap_deq", 1'b0, 0, '0, 1'b1, 40);

    // Overflow, oversize and underflow requests are ignored.
    do_reset();
    repeat (3) step("ovf_fill", 1'b1, 512, rand_data(), 1'b0, 0);
    step("ovf_fill64", 1'b1, 64, rand_data(), 1'b0, 0);
    step("ovf_enq", 1'b1, 512, rand_data(), 1'b0, 0);
    settle();
    chk32("overflow used", used_cnt, 32'd1600);
    do_reset();
    step("oversize", 1'b1, 513, rand_data(), 1'b0, 0);
    step("udf_fill", 1'b1, 16, rand_data(), 1'b0, 0);
    step("udf_deq", 1'b0, 0, '0, 1'b1, 24);
    settle();
    chk32("underflow used", used_cnt, 32'd16);

    // Full queue rejects even a small enqueue.
    do_reset();
    repeat (4) step("full_fill", 1'b1, 512, rand_data(), 1'b0, 0);
    step("full_enq", 1'b1, 1, rand_data(), 1'b1, 8);

    // Asynchronous reset mid-stream, between clock edges.
    step("async_pre", 1'b1, 512, rand_data(), 1'b0, 0);
    idle("async_idle");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk32("async used", used_cnt, 32'd0);
    chk32("async empty", empty_cnt, 32'd2048);
    chkout("async out", out_data, '0);
    model.delete();
    @(negedge clk);
    reset = 1'b0;

    // Randomised traffic, including illegal counts.
    for (int n = 0; n < 400; n++) begin
      int unsigned ic, oc;
      logic e, q;
      e  = ($urandom_range(0, 3) != 0);
      q  = ($urandom_range(0, 2) != 0);
      ic = ($urandom_range(0, 9) == 0) ? $urandom_range(513, 600) : $urandom_range(0, 512);
      oc = ($urandom_range(0, 9) == 0) ? $urandom_range(121, 200) : $urandom_range(0, 120);
      step("rand", e, ic, rand_data(), q, oc);
    end
    idle("final");

    guard = 0;
    while (exp_used_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_used_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations pending, required 0", exp_used_q.size());
    end
    eo = model_peek();
    chkout("final out", out_data, eo);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
